// File: rtl/uart_sram_transmitter.sv
// Reads 16-bit SRAM words and sends each as two 8N1 UART bytes, high byte first; optional trailing checksum.
// Latency: first start bit READ_LATENCY+3 cycles after Start; one byte takes 10*CLKS_PER_BIT cycles.
// Backpressure: none; Start is ignored while Busy. Optional checksum byte: define UART_TX_CHECKSUM_EN.
module uart_sram_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_READ,
        S_TX_WAIT,
        S_TX_SEND_HI,
        S_TX_SEND_LO,
        S_TX_DONE
`ifdef UART_TX_CHECKSUM_EN
        , S_TX_CSUM
`endif
    } tx_state_t;

    tx_state_t   state_q;
    logic        busy_q;
    logic        done_q;
    logic [17:0] sram_addr_q;
    logic [17:0] ptr_q;
    logic [17:0] rem_q;
    logic [15:0] word_q;
    logic [LW-1:0] wait_cnt_q;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    // Serializer state: bit_cnt 0 = start bit, 1..8 = data, 9 = stop
    logic        tx_q;
    logic        ser_act_q;
    logic [3:0]  bit_cnt_q;
    logic [CW-1:0] clk_cnt_q;
    logic [7:0]  sh_q;

    logic        ser_last_d;
    logic        ld_vld_d;
    logic [7:0]  ld_dat_d;

    assign SRAM_address = sram_addr_q;
    assign SRAM_we_n    = 1'b1;
    assign UART_TX_O    = tx_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

    // Decide when a byte is handed to the serializer; the next byte loads on the stop bit's last cycle so there is no idle gap
    always_comb begin
        ser_last_d = ser_act_q && (bit_cnt_q == 4'd9) && (clk_cnt_q == CLK_LAST);
        ld_vld_d   = 1'b0;
        ld_dat_d   = 8'h00;
        case (state_q)
            S_TX_SEND_HI: begin
                if (!ser_act_q) begin
                    ld_vld_d = 1'b1;
                    ld_dat_d = word_q[15:8];
                end else if (ser_last_d) begin
                    ld_vld_d = 1'b1;
                    ld_dat_d = word_q[7:0];
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            S_TX_SEND_LO: begin
                if (ser_last_d && (rem_q == 18'd0)) begin
                    ld_vld_d = 1'b1;
                    ld_dat_d = sum_q;
                end
            end
            S_TX_IDLE: begin
                if (Start && (Word_count == 18'd0)) begin
                    ld_vld_d = 1'b1;
                    ld_dat_d = 8'h00;
                end
            end
`endif
            default: ;
        endcase
    end

    // Bit-level 8N1 shifter: each bit held CLKS_PER_BIT cycles, line idles high
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            tx_q      <= 1'b1;
            ser_act_q <= 1'b0;
            bit_cnt_q <= 4'd0;
            clk_cnt_q <= '0;
            sh_q      <= 8'h00;
        end else if (ld_vld_d) begin
            tx_q      <= 1'b0;
            sh_q      <= ld_dat_d;
            bit_cnt_q <= 4'd0;
            clk_cnt_q <= '0;
            ser_act_q <= 1'b1;
        end else if (ser_act_q) begin
            if (clk_cnt_q == CLK_LAST) begin
                clk_cnt_q <= '0;
                if (bit_cnt_q == 4'd9) begin
                    ser_act_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q <= sh_q[0];
                        sh_q <= {1'b0, sh_q[7:1]};
                    end
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + CW'(1);
            end
        end
    end

    // Control FSM: fetch a word, send high then low byte, repeat, then pulse Done
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= S_TX_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sram_addr_q <= 18'd0;
            ptr_q       <= 18'd0;
            rem_q       <= 18'd0;
            word_q      <= 16'h0000;
            wait_cnt_q  <= '0;
`ifdef UART_TX_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_TX_IDLE: begin
                    if (Start) begin
                        busy_q <= 1'b1;
                        ptr_q  <= Base_address;
                        rem_q  <= Word_count;
`ifdef UART_TX_CHECKSUM_EN
                        sum_q  <= 8'h00;
`endif
                        if (Word_count == 18'd0) begin
`ifdef UART_TX_CHECKSUM_EN
                            state_q <= S_TX_CSUM;
`else
                            state_q <= S_TX_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_TX_READ;
                        end
                    end
                end
                S_TX_READ: begin
                    sram_addr_q <= ptr_q;
                    ptr_q       <= ptr_q + 18'd1;
                    wait_cnt_q  <= '0;
                    state_q     <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        word_q  <= SRAM_read_data;
                        state_q <= S_TX_SEND_HI;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + LW'(1);
                    end
                end
                S_TX_SEND_HI: begin
                    if (!ser_act_q) begin
`ifdef UART_TX_CHECKSUM_EN
                        sum_q <= sum_q + word_q[15:8];
`endif
                    end else if (ser_last_d) begin
`ifdef UART_TX_CHECKSUM_EN
                        sum_q <= sum_q + word_q[7:0];
`endif
                        rem_q   <= rem_q - 18'd1;
                        state_q <= S_TX_SEND_LO;
                    end
                end
                S_TX_SEND_LO: begin
                    if (ser_last_d) begin
                        if (rem_q == 18'd0) begin
`ifdef UART_TX_CHECKSUM_EN
                            state_q <= S_TX_CSUM;
`else
                            state_q <= S_TX_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_TX_READ;
                        end
                    end
                end
`ifdef UART_TX_CHECKSUM_EN
                S_TX_CSUM: begin
                    if (ser_last_d) begin
                        state_q <= S_TX_DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                S_TX_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_TX_IDLE;
                end
                default: state_q <= S_TX_IDLE;
            endcase
        end
    end

endmodule
